// File: rtl/pulse_gen_param.sv
// Configurable synchronous pulse generator: one-shot or periodic pulse train with
// programmable period/high time, busy/done status and a completed-period count.
module pulse_gen_param #(
  parameter int CNT_W  = 8,
  parameter int PCNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  high_time,
  output logic              signal,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] pulse_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    p_q, p_d, h_q, h_d, phase_q, phase_d;
  logic                mode_q, mode_d;
  logic                sig_q, sig_d, busy_q, busy_d, done_q, done_d;
  logic [PCNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]    p_in, h_in, phase_inc;

  // Clamp the requested config so 1 <= P and H <= P.
  assign p_in      = (period == '0) ? CNT_W'(1) : period;
  assign h_in      = (high_time > p_in) ? p_in : high_time;
  assign phase_inc = phase_q + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= CNT_W'(1);
      h_q     <= '0;
      mode_q  <= 1'b0;
      phase_q <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    h_d     = h_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          p_d     = p_in;
          h_d     = h_in;
          mode_d  = mode;
          phase_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          sig_d   = (h_in != '0);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          sig_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == p_q - CNT_W'(1)) begin
          cnt_d = cnt_q + PCNT_W'(1);
          if (!mode_q) begin
            state_d = IDLE;
            sig_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            phase_d = '0;
            sig_d   = (h_q != '0);
          end
        end else begin
          phase_d = phase_inc;
          sig_d   = (phase_inc < h_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    signal      = sig_q;
    busy        = busy_q;
    done        = done_q;
    pulse_count = cnt_q;
  end

endmodule

// File: tb/tb_pulse_gen_param.sv
// Directed bench for pulse_gen_param: waveform shapes, boundaries, stop/start corner
// cases and asynchronous reset, all against hand-computed expectations.
module tb_pulse_gen_param;
  localparam int CNT_W  = 8;
  localparam int PCNT_W = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              start, stop, mode;
  logic [CNT_W-1:0]  period, high_time;
  logic              signal, busy, done;
  logic [PCNT_W-1:0] pulse_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sig_v, busy_v, done_v;

  pulse_gen_param #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .period(period), .high_time(high_time), .signal(signal), .busy(busy),
    .done(done), .pulse_count(pulse_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample outputs n times (current cycle first, MSB-first) advancing one edge each.
  task automatic capture(input int n);
    sig_v = '0; busy_v = '0; done_v = '0;
    for (int i = 0; i < n; i++) begin
      sig_v  = {sig_v[30:0], signal};
      busy_v = {busy_v[30:0], busy};
      done_v = {done_v[30:0], done};
      tick();
    end
  endtask

  task automatic kick(input logic m, input int p, input int h);
    mode = m; period = CNT_W'(p); high_time = CNT_W'(h); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; mode = 0; period = 0; high_time = 0;
    #12;
    chk("rst_signal", signal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", pulse_count, 0);
    @(negedge clock); reset = 1'b0;
    tick();

    // one-shot P=8 H=3
    kick(0, 8, 3);
    capture(8);
    chk("os8_sig", sig_v, 32'b11100000);
    chk("os8_busy", busy_v, 32'hFF);
    chk("os8_done_early", done_v, 0);
    chk("os8_done", done, 1);
    chk("os8_busy_off", busy, 0);
    chk("os8_count", pulse_count, 1);
    tick();
    chk("os8_done_clr", done, 0);

    // periodic P=5 H=2 for 15 cycles then stop
    kick(1, 5, 2);
    capture(15);
    chk("per5_sig", sig_v, 32'b110001100011000);
    chk("per5_busy", busy_v, 32'h7FFF);
    chk("per5_done", done_v, 0);
    chk("per5_count", pulse_count, 3);
    halt();
    chk("per5_stop_busy", busy, 0);
    chk("per5_stop_sig", signal, 0);
    chk("per5_stop_done", done, 0);
    chk("per5_stop_count", pulse_count, 3);

    // H=0 periodic P=4
    kick(1, 4, 0);
    capture(12);
    chk("h0_sig", sig_v, 0);
    chk("h0_count", pulse_count, 3);
    halt();

    // H>P one-shot P=6
    kick(0, 6, 9);
    capture(6);
    chk("hbig_sig", sig_v, 32'b111111);
    chk("hbig_sig_after", signal, 0);
    chk("hbig_done", done, 1);

    // period=0 one-shot -> P=1
    kick(0, 0, 5);
    capture(1);
    chk("p0_sig", sig_v, 1);
    chk("p0_busy", busy_v, 1);
    chk("p0_done", done, 1);
    chk("p0_busy_off", busy, 0);
    chk("p0_count", pulse_count, 1);

    // restart attempt during RUN is ignored
    kick(0, 6, 3);
    sig_v = '0; busy_v = '0;
    for (int i = 0; i < 6; i++) begin
      sig_v  = {sig_v[30:0], signal};
      busy_v = {busy_v[30:0], busy};
      if (i == 2) begin start = 1'b1; period = 2; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("rst_ign_sig", sig_v, 32'b111000);
    chk("rst_ign_busy", busy_v, 32'h3F);
    chk("rst_ign_done", done, 1);
    chk("rst_ign_count", pulse_count, 1);

    // stop on the end-of-period edge
    kick(0, 4, 2);
    capture(3);
    halt();
    chk("stop_end_done", done, 0);
    chk("stop_end_count", pulse_count, 0);
    chk("stop_end_busy", busy, 0);
    tick();
    chk("stop_end_done2", done, 0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_sig", signal, 0);

    // periodic wrap of 2-bit counter, then async reset mid-RUN
    kick(1, 2, 1);
    capture(10);
    chk("wrap_count", pulse_count, 1);
    chk("wrap_sig", signal, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_sig", signal, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", pulse_count, 0);
    @(negedge clock); reset = 1'b0;
    tick();
    chk("arst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
